// File: rtl/vgabios_rd_ctrl_if.sv
// Host-side request/response bus plus the ROM enable/address port of the
// VGA BIOS read controller, bundled as one interface.
interface vgabios_rd_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        flush;
  logic        rom_en;
  logic [8:0]  rom_address;
  logic        rom_ready;
  logic [31:0] rom_data;
  logic [15:0] hit_count;

  modport slave (
    input  req_valid, req_addr, req_be, rsp_ready, flush, rom_ready, rom_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, rom_en, rom_address, hit_count
  );

  modport master (
    output req_valid, req_addr, req_be, rsp_ready, flush, rom_ready, rom_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rom_en, rom_address, hit_count
  );
endinterface

// File: rtl/vgabios_rd_ctrl.sv
// Read controller in front of the 512x32 VGA BIOS ROM: one-word last-read
// buffer, byte-lane masking and a bounded wait for the ROM response.
module vgabios_rd_ctrl #(
  parameter int unsigned TIMEOUT   = 8,
  parameter logic [31:0] FILL_DATA = 32'hFFFF_FFFF
) (
  input logic              ib_clk,
  input logic              ib_rst_n,
  vgabios_rd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        rom_en_q;
  logic [8:0]  rom_address_q;
  logic [3:0]  be_q;
  logic        buf_valid_q;
  logic [8:0]  buf_tag_q;
  logic [31:0] buf_data_q;
  logic [7:0]  tmo_cnt_q;
  logic [15:0] hit_count_q;

  logic        accept_s;
  logic [8:0]  word_idx_s;
  logic        hit_s;
  logic        tmo_s;
  logic [7:0]  tmo_cnt_d;
  logic [15:0] hit_count_d;

  function automatic logic [31:0] lane_mask(input logic [31:0] word, input logic [3:0] be);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? word[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

  // Request decode, buffer lookup and counter next values
  always_comb begin
    accept_s    = bus.req_valid && req_ready_q;
    word_idx_s  = bus.req_addr[10:2];
    hit_s       = buf_valid_q && (buf_tag_q == word_idx_s) && !bus.flush;
    tmo_cnt_d   = tmo_cnt_q + 8'd1;
    tmo_s       = (tmo_cnt_d == TMO_LIMIT);
    if (hit_count_q == 16'hFFFF) begin
      hit_count_d = hit_count_q;
    end else begin
      hit_count_d = hit_count_q + 16'd1;
    end
  end

  // Controller FSM with registered outputs and last-read buffer
  always_ff @(posedge ib_clk or negedge ib_rst_n) begin
    if (!ib_rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0000_0000;
      rsp_err_q     <= 1'b0;
      rom_en_q      <= 1'b0;
      rom_address_q <= 9'h000;
      be_q          <= 4'h0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= 9'h000;
      buf_data_q    <= 32'h0000_0000;
      tmo_cnt_q     <= 8'h00;
      hit_count_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept_s) begin
            be_q        <= bus.req_be;
            req_ready_q <= 1'b0;
            if (bus.req_be == 4'h0) begin
              rsp_data_q  <= 32'h0000_0000;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (hit_s) begin
              rsp_data_q  <= lane_mask(buf_data_q, bus.req_be);
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              hit_count_q <= hit_count_d;
              state_q     <= RESP;
            end else begin
              rom_address_q <= word_idx_s;
              rom_en_q      <= 1'b1;
              tmo_cnt_q     <= 8'h00;
              state_q       <= FETCH;
            end
          end
        end
        FETCH: begin
          req_ready_q <= 1'b0;
          if (rom_en_q && bus.rom_ready) begin
            buf_data_q  <= bus.rom_data;
            buf_tag_q   <= rom_address_q;
            buf_valid_q <= 1'b1;
            rsp_data_q  <= lane_mask(bus.rom_data, be_q);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rom_en_q    <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_s) begin
            // ROM never answered: return fill pattern, leave the buffer alone
            rsp_data_q  <= lane_mask(FILL_DATA, be_q);
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            rom_en_q    <= 1'b0;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        RESP: begin
          req_ready_q <= 1'b0;
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rom_en_q    <= 1'b0;
        end
      endcase
      // Flush overrides any buffer fill scheduled above in the same cycle
      if (bus.flush) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rom_en      = rom_en_q;
  assign bus.rom_address = rom_address_q;
  assign bus.hit_count   = hit_count_q;

endmodule

// File: tb/tb_vgabios_rd_ctrl.sv
// Directed bench for vgabios_rd_ctrl with a registered-enable ROM model.
module tb_vgabios_rd_ctrl;

  logic ib_clk;
  logic ib_rst_n;
  int   checks;
  int   failures;

  vgabios_rd_ctrl_if bus();

  vgabios_rd_ctrl #(
    .TIMEOUT  (8),
    .FILL_DATA(32'hFFFF_FFFF)
  ) dut (
    .ib_clk  (ib_clk),
    .ib_rst_n(ib_rst_n),
    .bus     (bus.slave)
  );

  initial ib_clk = 1'b0;
  always #5 ib_clk = ~ib_clk;

  logic [31:0] rom_mem [0:511];
  logic        rom_stall;
  int          rom_en_cnt;

  // ROM model: enable registered one cycle, ready suppressed while stalled
  always @(posedge ib_clk or negedge ib_rst_n) begin
    if (!ib_rst_n) begin
      bus.rom_ready <= 1'b0;
      bus.rom_data  <= 32'hzzzz_zzzz;
    end else begin
      bus.rom_ready <= bus.rom_en && !rom_stall;
      bus.rom_data  <= bus.rom_en ? rom_mem[bus.rom_address] : 32'hzzzz_zzzz;
    end
  end

  initial rom_en_cnt = 0;
  always @(posedge ib_clk) begin
    if (bus.rom_en === 1'b1) rom_en_cnt <= rom_en_cnt + 1;
  end

  task automatic tick();
    @(posedge ib_clk);
    #1;
  endtask

  task automatic issue(input logic [10:0] addr, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_be    = be;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    ib_rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 ||
        bus.rsp_err !== 1'b0 || bus.rom_en !== 1'b0 || bus.rom_address !== 9'h0 ||
        bus.hit_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h err=%b en=%b addr=%h hits=%h required 1 0 0 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rom_en,
               bus.rom_address, bus.hit_count);
    end
    ib_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_miss_hit();
    int e0;
    e0 = rom_en_cnt;
    issue(11'h040, 4'hF);
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rom_address !== 9'h010 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_n1: en=%b addr=%h vld=%b required 1 010 0", bus.rom_en, bus.rom_address, bus.rsp_valid);
    end
    tick();
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_n2: en=%b vld=%b required 1 0", bus.rom_en, bus.rsp_valid);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hAA55_1234 || bus.rsp_err !== 1'b0 ||
        bus.rom_en !== 1'b0 || (rom_en_cnt - e0) != 2) begin
      failures++;
      $display("FAIL miss_n3: vld=%b data=%h err=%b en=%b en_cycles=%0d required 1 aa551234 0 0 2",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rom_en, rom_en_cnt - e0);
    end
    handshake();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL miss_release: vld=%b rdy=%b required 0 1", bus.rsp_valid, bus.req_ready);
    end
    e0 = rom_en_cnt;
    issue(11'h041, 4'b0010);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_1200 || bus.rom_en !== 1'b0 ||
        bus.hit_count !== 16'd1 || (rom_en_cnt - e0) != 0) begin
      failures++;
      $display("FAIL hit_n1: vld=%b data=%h en=%b hits=%0d en_cycles=%0d required 1 00001200 0 1 0",
               bus.rsp_valid, bus.rsp_data, bus.rom_en, bus.hit_count, rom_en_cnt - e0);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int e0;
    e0 = rom_en_cnt;
    issue(11'h042, 4'hF);
    bus.req_valid = 1'b1;
    bus.req_addr  = 11'h000;
    bus.req_be    = 4'hF;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hAA55_1234 || bus.rsp_err !== 1'b0 ||
          bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: vld=%b data=%h err=%b rdy=%b required 1 aa551234 0 0",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    handshake();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.hit_count !== 16'd2 || (rom_en_cnt - e0) != 0) begin
      failures++;
      $display("FAIL backpressure_after: rdy=%b hits=%0d en_cycles=%0d required 1 2 0",
               bus.req_ready, bus.hit_count, rom_en_cnt - e0);
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    issue(11'h040, 4'hF);
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rom_address !== 9'h010) begin
      failures++;
      $display("FAIL flush_miss: en=%b addr=%h required 1 010", bus.rom_en, bus.rom_address);
    end
    repeat (2) tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hAA55_1234 || bus.hit_count !== 16'd2) begin
      failures++;
      $display("FAIL flush_refetch: vld=%b data=%h hits=%0d required 1 aa551234 2",
               bus.rsp_valid, bus.rsp_data, bus.hit_count);
    end
    handshake();
    issue(11'h080, 4'hF);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL flush_capture_data: vld=%b data=%h required 1 deadbeef", bus.rsp_valid, bus.rsp_data);
    end
    handshake();
    issue(11'h080, 4'hF);
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rom_address !== 9'h020) begin
      failures++;
      $display("FAIL flush_capture_miss: en=%b addr=%h required 1 020", bus.rom_en, bus.rom_address);
    end
    repeat (2) tick();
    checks++;
    if (bus.rsp_data !== 32'hDEAD_BEEF || bus.hit_count !== 16'd2) begin
      failures++;
      $display("FAIL flush_capture_refetch: data=%h hits=%0d required deadbeef 2", bus.rsp_data, bus.hit_count);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int e0;
    rom_stall = 1'b1;
    e0 = rom_en_cnt;
    issue(11'h014, 4'b1100);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (bus.rom_en !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait[%0d]: en=%b vld=%b required 1 0", k, bus.rom_en, bus.rsp_valid);
      end
      tick();
    end
    checks++;
    if (bus.rom_en !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hFFFF_0000 ||
        bus.rsp_err !== 1'b1 || (rom_en_cnt - e0) != 8) begin
      failures++;
      $display("FAIL timeout_resp: en=%b vld=%b data=%h err=%b en_cycles=%0d required 0 1 ffff0000 1 8",
               bus.rom_en, bus.rsp_valid, bus.rsp_data, bus.rsp_err, rom_en_cnt - e0);
    end
    handshake();
    rom_stall = 1'b0;
    checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release: err=%b vld=%b required 0 0", bus.rsp_err, bus.rsp_valid);
    end
    issue(11'h080, 4'b0001);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00EF || bus.hit_count !== 16'd3 ||
        bus.rom_en !== 1'b0) begin
      failures++;
      $display("FAIL timeout_buffer_kept: vld=%b data=%h hits=%0d en=%b required 1 000000ef 3 0",
               bus.rsp_valid, bus.rsp_data, bus.hit_count, bus.rom_en);
    end
    handshake();
    issue(11'h014, 4'hF);
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rom_address !== 9'h005) begin
      failures++;
      $display("FAIL timeout_no_fill: en=%b addr=%h required 1 005", bus.rom_en, bus.rom_address);
    end
    repeat (2) tick();
    checks++;
    if (bus.rsp_data !== 32'h0123_4567 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_refetch: data=%h err=%b required 01234567 0", bus.rsp_data, bus.rsp_err);
    end
    handshake();
  endtask

  task automatic test_zero_be();
    int e0;
    e0 = rom_en_cnt;
    issue(11'h7FF, 4'h0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0 ||
        bus.hit_count !== 16'd3) begin
      failures++;
      $display("FAIL zero_be_miss_addr: vld=%b data=%h err=%b hits=%0d required 1 0 0 3",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.hit_count);
    end
    handshake();
    issue(11'h015, 4'h0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.hit_count !== 16'd3 ||
        (rom_en_cnt - e0) != 0) begin
      failures++;
      $display("FAIL zero_be_buffered_addr: vld=%b data=%h hits=%0d en_cycles=%0d required 1 0 3 0",
               bus.rsp_valid, bus.rsp_data, bus.hit_count, rom_en_cnt - e0);
    end
    handshake();
  endtask

  task automatic test_reset_mid_fetch();
    issue(11'h040, 4'hF);
    ib_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rom_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.hit_count !== 16'h0 ||
        bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async: en=%b vld=%b hits=%0d rdy=%b required 0 0 0 1",
               bus.rom_en, bus.rsp_valid, bus.hit_count, bus.req_ready);
    end
    tick();
    ib_rst_n = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1 0", bus.req_ready, bus.rsp_valid);
    end
    issue(11'h014, 4'hF);
    checks++;
    if (bus.rom_en !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_buffer_cleared: en=%b vld=%b required 1 0", bus.rom_en, bus.rsp_valid);
    end
    repeat (2) tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0123_4567 || bus.hit_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_refetch: vld=%b data=%h hits=%0d required 1 01234567 0",
               bus.rsp_valid, bus.rsp_data, bus.hit_count);
    end
    handshake();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rom_stall     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 11'h000;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    for (int i = 0; i < 512; i++) rom_mem[i] = 32'h0000_0000;
    rom_mem[16] = 32'hAA55_1234;
    rom_mem[32] = 32'hDEAD_BEEF;
    rom_mem[5]  = 32'h0123_4567;
    ib_rst_n = 1'b1;
    #2;
    test_reset();
    test_miss_hit();
    test_backpressure();
    test_flush();
    test_timeout();
    test_zero_be();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vgabios_rd_ctrl.md
Name: vgabios_rd_ctrl

Overview:
Read controller that sits directly upstream of the 512x32 VGA BIOS ROM block. It accepts byte-addressed, byte-enabled read requests from the host expansion-ROM target and drives the ROM's enable/address interface. It holds the ROM enable until data returns and keeps a one-word last-read buffer, so repeated byte and word reads of the same dword skip the ROM. It also masks byte lanes and times out if the ROM does not respond.

Parameters:
TIMEOUT, 8, max cycles in FETCH waiting for rom_ready before error response (1..255)
FILL_DATA, 32'hFFFF_FFFF, data returned on timeout (before lane masking)

Ports:
ib_clk  in  1  clock
ib_rst_n  in  1  asynchronous active-low reset
req_valid  in  1  read request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  11  byte address into 2 KB ROM; word index = req_addr[10:2]
req_be  in  4  active-high byte enables, bit i = byte lane i (data[8i+7:8i])
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  32  ROM word, disabled lanes forced to 0
rsp_err  out  1  response produced by timeout
flush  in  1  invalidate last-read buffer
rom_en  out  1  to ROM ib_en
rom_address  out  9  to ROM ib_address
rom_ready  in  1  from ROM ib_ready (ROM registers ib_en one cycle)
rom_data  in  32  from ROM ib_data_out (tri-stated while rom_en low; only sampled while rom_en=1)
hit_count  out  16  saturating count of buffer hits

Behaviour:
- Reset values: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; rom_en=0; rom_address=0; buffer valid=0, tag=0, data=0; timeout counter=0; hit_count=0.
- States: IDLE, FETCH, RESP.
- IDLE: req_ready=1. On accept, latch word index and be.
  - be==0: go to RESP with data 0, err 0. No ROM access, not counted as a hit.
  - Else hit (buf_valid && tag==req_addr[10:2] && !flush this cycle): go to RESP with buffer data masked, err 0. hit_count += 1, saturating at 16'hFFFF.
  - Else: go to FETCH. rom_address = word index, rom_en=1 from the next cycle. Clear the timeout counter.
- FETCH: req_ready=0. rom_en held 1 and rom_address held stable. Each cycle with rom_ready=0 increments the counter.
  - rom_en && rom_ready: capture rom_data into the buffer (tag=word index, valid=1). Load rsp_data with the masked word, rom_en=0 next cycle, go to RESP.
  - Counter reaches TIMEOUT without rom_ready: rsp_data = FILL_DATA masked, rsp_err=1, buffer unchanged, rom_en=0, go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_err stable. req_ready=0. On rsp_ready, rsp_valid=0 next cycle, rsp_err=0, go to IDLE. The next request can be accepted the cycle after the handshake.
- Latency from accept cycle N:
  - hit or be==0: rsp_valid high at N+1.
  - miss: rom_en high at N+1, rom_ready high at N+2, rsp_valid high at N+3.
- Masking: rsp_data[8i+7:8i] = req_be[i] ? word[8i+7:8i] : 8'h00.
- flush: clears buf_valid at the next edge in any state. If flush coincides with a FETCH capture, the response still uses the captured data but buf_valid ends 0 (flush wins).
- rom_en never asserts outside FETCH. Exactly one ROM access per miss.
- Async reset mid-FETCH or mid-RESP: all outputs return to reset values immediately, and any pending response is dropped.

Test Plan:
- Miss then hit: ROM word 0x10 = 32'hAA55_1234; request addr 11'h040, be 4'hF -> rom_en high 2 cycles with rom_address 9'h010, rsp_data 32'hAA55_1234 at N+3; repeat with addr 11'h041, be 4'b0010 -> rsp_data 32'h0000_1200 at N+1, no rom_en, hit_count=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, rsp_err stable, req_ready=0 throughout; a req_valid during that time is not accepted.
- Flush: after a buffered read of word 0x10, pulse flush, then re-read addr 11'h040 -> rom_en reasserts (miss), hit_count unchanged. Flush in the same cycle as the FETCH capture -> correct data returned, next same-word read is a miss.
- Timeout: TIMEOUT=8, ROM model with rom_ready tied 0, be 4'b1100 -> rsp_data 32'hFFFF_0000, rsp_err=1, rom_en low after 8 FETCH cycles, buffer not updated.
- Zero byte-enable: be=0 at any address -> rsp_data 0 at N+1, rom_en never asserted.
- Reset mid-FETCH: deassert ib_rst_n while rom_en=1 -> rom_en, rsp_valid, hit_count go 0 asynchronously and req_ready=1 after release; a following request to the previously buffered word is a miss.
